// File: rtl/div_seq_if.sv
// div_seq_if -- request/response bundle for the sequential divider.
//   start      : operation request, sampled only while the divider is idle
//   x, y       : dividend (32b) and divisor (16b)
//   word_op    : 1 = 16-bit quotient/remainder, 0 = 8-bit
//   signed_op  : 1 = signed divide (only honoured with DIV_SEQ_SIGNED_EN)
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   exc        : divide error, qualified by done
//   out        : {rem, quo} result, updated only on successful completion
// master = requester side, slave = divider side.
interface div_seq_if;
  logic        start;
  logic [31:0] x;
  logic [15:0] y;
  logic        word_op;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic        exc;
  logic [31:0] out;

  modport master (
    output start, x, y, word_op, signed_op,
    input  busy, done, exc, out
  );

  modport slave (
    input  start, x, y, word_op, signed_op,
    output busy, done, exc, out
  );
endinterface

// File: rtl/div_seq.sv
// div_seq -- x86-style DIV/IDIV r/m16 and r/m8 sequential divider.
// Restoring division, one quotient bit per cycle, MSB first.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : div_seq_if.slave (start/x/y/word_op/signed_op in,
//          busy/done/exc/out out)
// Build option: define DIV_SEQ_SIGNED_EN to compile in signed (IDIV)
// handling; without it signed_op is ignored and every op is unsigned.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// PREP  | form magnitudes, check divisor zero / quotient overflow
// CALC  | restoring division, N = 16 (word) or 8 (byte) iterations
// FIX   | apply signs, signed range check, publish result
module div_seq (
  input logic     clk,
  input logic     rst,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t      state;
  logic [31:0] x_r;
  logic [15:0] y_r;
  logic        word_r;
  logic [15:0] acc;       // partial remainder, always < divisor
  logic [15:0] q;         // dividend low bits shifting out, quotient in
  logic [15:0] d;         // divisor magnitude
  logic [4:0]  cnt;       // iterations remaining
  logic        busy_r;
  logic        done_r;
  logic        exc_r;
  logic [31:0] out_r;

`ifdef DIV_SEQ_SIGNED_EN
  logic        signed_r;
  logic        neg_q;
  logic        neg_r;
  logic        x_neg;
  logic        y_neg;
`endif

  // PREP: magnitudes and early error check
  logic [31:0] x_mag;
  logic [15:0] y_mag;
  logic [15:0] upper;
  logic [15:0] lower;
  logic        prep_err;

  always_comb begin
`ifdef DIV_SEQ_SIGNED_EN
    x_neg = signed_r & (word_r ? x_r[31] : x_r[15]);
    y_neg = signed_r & (word_r ? y_r[15] : y_r[7]);
    if (word_r) begin
      x_mag = x_neg ? (32'd0 - x_r) : x_r;
      y_mag = y_neg ? (16'd0 - y_r) : y_r;
    end else begin
      x_mag = {16'h0, (x_neg ? (16'd0 - x_r[15:0]) : x_r[15:0])};
      y_mag = {8'h0, (y_neg ? (8'd0 - y_r[7:0]) : y_r[7:0])};
    end
`else
    x_mag = word_r ? x_r : {16'h0, x_r[15:0]};
    y_mag = word_r ? y_r : {8'h0, y_r[7:0]};
`endif
    // byte ops park the low dividend byte in q[15:8] so the MSB-first
    // shift is the same for both widths
    upper    = word_r ? x_mag[31:16] : {8'h0, x_mag[15:8]};
    lower    = word_r ? x_mag[15:0]  : {x_mag[7:0], 8'h0};
    prep_err = (y_mag == 16'd0) || (upper >= y_mag);
  end

  // CALC: one restoring step
  logic [16:0] acc_sh;
  logic        ge;
  logic [16:0] acc_sub;

  always_comb begin
    acc_sh  = {acc, q[15]};
    ge      = acc_sh >= {1'b0, d};
    acc_sub = acc_sh - {1'b0, d};
  end

  // FIX: sign application and final range check
  logic [15:0] quo_mag;
  logic [15:0] rem_mag;
  logic [15:0] quo;
  logic [15:0] rem;
  logic        fix_err;
  logic [31:0] fix_out;

  always_comb begin
    quo_mag = word_r ? q   : {8'h0, q[7:0]};
    rem_mag = word_r ? acc : {8'h0, acc[7:0]};
`ifdef DIV_SEQ_SIGNED_EN
    quo = neg_q ? (16'd0 - quo_mag) : quo_mag;
    rem = neg_r ? (16'd0 - rem_mag) : rem_mag;
    fix_err = 1'b0;
    if (signed_r) begin
      if (neg_q)
        fix_err = quo_mag > (word_r ? 16'd32768 : 16'd128);
      else
        fix_err = quo_mag > (word_r ? 16'd32767 : 16'd127);
    end
`else
    quo     = quo_mag;
    rem     = rem_mag;
    fix_err = 1'b0;
`endif
    fix_out = word_r ? {rem, quo} : {16'h0, rem[7:0], quo[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x_r    <= 32'h0;
      y_r    <= 16'h0;
      word_r <= 1'b0;
      acc    <= 16'h0;
      q      <= 16'h0;
      d      <= 16'h0;
      cnt    <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      exc_r  <= 1'b0;
      out_r  <= 32'h0;
`ifdef DIV_SEQ_SIGNED_EN
      signed_r <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      exc_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_r    <= bus.x;
            y_r    <= bus.y;
            word_r <= bus.word_op;
`ifdef DIV_SEQ_SIGNED_EN
            signed_r <= bus.signed_op;
`endif
            busy_r <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          if (prep_err) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            exc_r  <= 1'b1;
            state  <= IDLE;
          end else begin
            acc   <= upper;
            q     <= lower;
            d     <= y_mag;
            cnt   <= word_r ? 5'd16 : 5'd8;
`ifdef DIV_SEQ_SIGNED_EN
            neg_q <= x_neg ^ y_neg;
            neg_r <= x_neg;
`endif
            state <= CALC;
          end
        end
        CALC: begin
          acc <= ge ? acc_sub[15:0] : acc_sh[15:0];
          q   <= {q[14:0], ge};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= FIX;
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          exc_r  <= fix_err;
          if (!fix_err)
            out_r <= fix_out;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.exc  = exc_r;
  assign bus.out  = out_r;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have no parameters; operand widths are fixed at 32-bit dividend and 16-bit divisor.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 x  input  32  dividend; word op uses x[31:0], byte op uses x[15:0].
REQ-006 y  input  16  divisor; word op uses y[15:0], byte op uses y[7:0].
REQ-007 word_op  input  1  1 = DIV/IDIV r/m16, 0 = r/m8; sampled with start.
REQ-008 signed_op  input  1  1 = IDIV, 0 = DIV; sampled with start.
REQ-009 busy  output  1  high in PREP, CALC and FIX.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 exc  output  1  divide error (INT 0), valid only while done=1.
REQ-012 out  output  32  word: {rem16, quo16}; byte: {16'd0, rem8, quo8}.

Function
REQ-013 The block SHALL register x, y, word_op and signed_op on the edge where start=1 in IDLE; operands SHALL NOT be required stable afterwards.
REQ-014 States SHALL be IDLE, PREP, CALC and FIX.
REQ-015 IDLE->PREP on start. PREP->CALC normally; PREP->IDLE with done=1 and exc=1 on error. CALC->FIX after N iterations. FIX->IDLE with done=1.
REQ-016 N SHALL be 16 for word ops and 8 for byte ops.
REQ-017 PREP SHALL form magnitudes: two's-complement absolute value if signed_op, else the raw value.
REQ-018 PREP SHALL flag an error if the divisor is 0.
REQ-019 PREP SHALL flag an error if the dividend's upper half (|x|[31:16] word, |x|[15:8] byte) is >= |divisor|.
REQ-020 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first.
REQ-021 FIX SHALL negate the quotient when the operand signs differ, and give the remainder the dividend's sign.
REQ-022 FIX SHALL flag an error if a signed quotient is outside -32768..32767 (word) or -128..127 (byte).
REQ-023 Quotient SHALL truncate toward zero, with |rem| < |divisor|.
REQ-024 Latency, start edge = cycle 0: done high in cycle N+3 (word 19, byte 11); on a PREP error, done high in cycle 2.
REQ-025 out SHALL update only when done=1 with exc=0, and SHALL otherwise hold its last value.
REQ-026 start while busy=1 SHALL be ignored with no effect on the running operation.
REQ-027 start in the same cycle as done SHALL be accepted, since the state is IDLE.
REQ-028 exc SHALL be 0 whenever done=0.

Reset
REQ-029 rst=1 SHALL force IDLE with busy=0, done=0, exc=0, out=32'h0 and the iteration counter at 0.
REQ-030 rst mid-operation SHALL abort the operation with no done pulse, and the block SHALL accept start on the first cycle after rst deasserts.
REQ-031 rst SHALL take priority over start.

Configuration
REQ-032 With macro DIV_SEQ_SIGNED_EN defined, signed (IDIV) handling per REQ-017, REQ-021 and REQ-022 SHALL be compiled in.
REQ-033 Without DIV_SEQ_SIGNED_EN, signed_op SHALL be ignored, all operations SHALL be unsigned, and the absolute-value and sign-fix logic SHALL be absent; FIX SHALL still take one cycle, so latency is unchanged.

Verification
REQ-034 Word DIV: x=32'h000186A0, y=16'h012C -> done at cycle 19, exc=0, out=32'h0064014D.
REQ-035 Byte DIV: x=32'h00000064, y=16'h0007, word_op=0 -> done at cycle 11, out=32'h0000020E.
REQ-036 Word IDIV: x=32'hFFFFFFF9, y=16'h0002 -> out=32'hFFFFFFFD (quo -3, rem -1). Word IDIV: x=32'h00010000, y=16'h0002 -> exc=1 at cycle 19, out unchanged.
REQ-037 Word DIV: y=0 -> exc=1 at cycle 2, out unchanged. Word DIV: x=32'h00020000, y=16'h0001 -> exc=1 at cycle 2.
REQ-038 Second start at cycle 5 of a word op -> ignored, single done at cycle 19. New start in the done cycle -> second done 19 cycles later.
REQ-039 rst asserted at cycle 8 of a word op -> no done pulse, all outputs at reset values, next start completes normally.
